// File: rtl/uart_sdram_bridge.sv
`default_nettype none
// uart_sdram_bridge: decodes 'R' + 24-bit address frames from a UART, reads one
// SDRAM word and returns it high byte first; failures answer 0x3F or 0xEE.
module uart_sdram_bridge #(
    parameter int unsigned RD_TIMEOUT   = 255,
    parameter int unsigned BYTE_TIMEOUT = 1000000
) (
    input  logic        clk_100MHz,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [23:0] addr,
    output logic        rd_req,
    input  logic [15:0] rd_data,
    input  logic        rd_ready,
    output logic        busy,
    output logic        err
);

    localparam logic [31:0] C_BYTE_LAST = 32'(BYTE_TIMEOUT - 1);
    localparam logic [31:0] C_RD_LAST   = 32'(RD_TIMEOUT - 1);
    localparam logic [7:0]  C_CMD_READ  = 8'h52;
    localparam logic [7:0]  C_ERR_CMD   = 8'h3F;
    localparam logic [7:0]  C_ERR_RD    = 8'hEE;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        REQ    = 3'd2,
        TX_HI  = 3'd3,
        TX_LO  = 3'd4,
        TX_ERR = 3'd5
    } state_t;

    // Transmit phases: wait for idle line, guard cycle, wait for frame done.
    typedef enum logic [1:0] {
        PH_START = 2'd0,
        PH_GUARD = 2'd1,
        PH_DRAIN = 2'd2
    } tx_ph_t;

    state_t      state_q, state_d;
    tx_ph_t      tx_ph_q, tx_ph_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [23:0] addr_q, addr_d;
    logic        rd_req_q, rd_req_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [31:0] timer_q, timer_d;
    logic        err_q, err_d;
    logic        busy_q;
    logic        in_tx;

    assign in_tx    = (state_q == TX_HI) || (state_q == TX_LO) || (state_q == TX_ERR);
    assign tx_start = in_tx && (tx_ph_q == PH_START) && !tx_busy;

    assign tx_data = tx_data_q;
    assign addr    = addr_q;
    assign rd_req  = rd_req_q;
    assign busy    = busy_q;
    assign err     = err_q;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_ph_q   <= PH_START;
            cnt_q     <= 2'd0;
            shift_q   <= 16'd0;
            addr_q    <= 24'd0;
            rd_req_q  <= 1'b0;
            hold_q    <= 16'd0;
            tx_data_q <= 8'd0;
            timer_q   <= 32'd0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_ph_q   <= tx_ph_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            rd_req_q  <= rd_req_d;
            hold_q    <= hold_d;
            tx_data_q <= tx_data_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_ph_d   = tx_ph_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        rd_req_d  = rd_req_q;
        hold_d    = hold_q;
        tx_data_d = tx_data_q;
        timer_d   = timer_q;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == C_CMD_READ) begin
                        cnt_d   = 2'd0;
                        timer_d = 32'd0;
                        state_d = ADDR;
                    end else begin
                        err_d     = 1'b1;
                        tx_data_d = C_ERR_CMD;
                        tx_ph_d   = PH_START;
                        state_d   = TX_ERR;
                    end
                end
            end

            ADDR: begin
                // Expiry wins over a byte arriving in the same cycle.
                if (timer_q == C_BYTE_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (rx_valid) begin
                    shift_d = {shift_q[7:0], rx_data};
                    cnt_d   = cnt_q + 2'd1;
                    timer_d = 32'd0;
                    if (cnt_q == 2'd2) begin
                        addr_d   = {shift_q, rx_data};
                        rd_req_d = 1'b1;
                        state_d  = REQ;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            REQ: begin
                err_d = rx_valid;
                if (rd_ready) begin
                    hold_d    = rd_data;
                    tx_data_d = rd_data[15:8];
                    rd_req_d  = 1'b0;
                    tx_ph_d   = PH_START;
                    state_d   = TX_HI;
                end else if (timer_q == C_RD_LAST) begin
                    rd_req_d  = 1'b0;
                    err_d     = 1'b1;
                    tx_data_d = C_ERR_RD;
                    tx_ph_d   = PH_START;
                    state_d   = TX_ERR;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            TX_HI, TX_LO, TX_ERR: begin
                err_d = rx_valid;
                case (tx_ph_q)
                    PH_START: if (!tx_busy) tx_ph_d = PH_GUARD;
                    PH_GUARD: tx_ph_d = PH_DRAIN;
                    default: begin
                        if (!tx_busy) begin
                            tx_ph_d = PH_START;
                            if (state_q == TX_HI) begin
                                tx_data_d = hold_q[7:0];
                                state_d   = TX_LO;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                endcase
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_sdram_bridge.sv
`default_nettype none
// tb_uart_sdram_bridge: directed frames against hand-computed bytes, addresses
// and error strobes, with a small transmitter model supplying tx_busy.
module tb_uart_sdram_bridge;

    localparam int RD_TO   = 20;
    localparam int BYTE_TO = 200;

    logic        clk_100MHz = 1'b0;
    logic        rst_n      = 1'b0;
    logic [7:0]  rx_data    = 8'h00;
    logic        rx_valid   = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [23:0] addr;
    logic        rd_req;
    logic [15:0] rd_data    = 16'h0000;
    logic        rd_ready   = 1'b0;
    logic        busy;
    logic        err;

    logic        busy_force = 1'b0;
    logic [3:0]  tx_cnt_q;
    int          n_tests    = 0;
    int          n_fail     = 0;
    int          err_cnt    = 0;
    int          bad_start  = 0;
    int          rdreq_rise = 0;
    logic        rd_req_prev = 1'b0;
    logic [7:0]  tx_q[$];

    uart_sdram_bridge #(
        .RD_TIMEOUT   (RD_TO),
        .BYTE_TIMEOUT (BYTE_TO)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .addr       (addr),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Transmitter model: busy for 8 cycles starting the cycle after tx_start.
    always @(posedge clk_100MHz) begin
        if (!rst_n)               tx_cnt_q <= 4'd0;
        else if (tx_start)        tx_cnt_q <= 4'd8;
        else if (tx_cnt_q != 4'd0) tx_cnt_q <= tx_cnt_q - 4'd1;
    end
    assign tx_busy = (tx_cnt_q != 4'd0) || busy_force;

    always @(negedge clk_100MHz) begin
        if (tx_start) tx_q.push_back(tx_data);
        if (tx_start && tx_busy) bad_start++;
        if (err) err_cnt++;
        if (rd_req && !rd_req_prev) rdreq_rise++;
        rd_req_prev = rd_req;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] a);
        send_byte(8'h52);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic pulse_rd(input logic [15:0] d);
        rd_data  = d;
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            tick(1);
            n++;
        end
        tick(2);
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int e0, q0, r0, n;

        tick(2);
        check("reset_outputs", {addr, rd_req, tx_start, busy, err}, 32'd0);
        check("reset_txdata", {24'd0, tx_data}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Normal read of 0x123456 returning 0xBEEF.
        e0 = err_cnt; q0 = tx_q.size(); r0 = rdreq_rise;
        send_frame(24'h123456);
        check("rdreq_after_byte4", {31'd0, rd_req}, 32'd1);
        check("addr_123456", {8'd0, addr}, 32'h123456);
        check("busy_in_req", {31'd0, busy}, 32'd1);
        pulse_rd(16'hBEEF);
        check("hi_start_latency", {23'd0, rd_req, tx_start, tx_data}, {23'd0, 1'b0, 1'b1, 8'hBE});
        wait_idle("read_idle");
        check("read_tx_count", tx_q.size() - q0, 32'd2);
        check("read_bytes", {16'd0, tx_q[q0], tx_q[q0+1]}, 32'hBEEF);
        check("read_no_err", err_cnt - e0, 32'd0);
        check("read_one_req", rdreq_rise - r0, 32'd1);

        // Unknown command byte.
        e0 = err_cnt; q0 = tx_q.size(); r0 = rdreq_rise;
        send_byte(8'h41);
        check("badcmd_err", {31'd0, err}, 32'd1);
        wait_idle("badcmd_idle");
        check("badcmd_err_once", err_cnt - e0, 32'd1);
        check("badcmd_tx", {tx_q.size() - q0 == 1, 23'd0, tx_q[q0]}, {1'b1, 23'd0, 8'h3F});
        check("badcmd_no_req", rdreq_rise - r0, 32'd0);

        // Inter-byte timeout, then a clean frame.
        e0 = err_cnt; q0 = tx_q.size();
        send_byte(8'h52);
        send_byte(8'h12);
        tick(BYTE_TO + 10);
        check("bto_err", err_cnt - e0, 32'd1);
        check("bto_no_tx", tx_q.size() - q0, 32'd0);
        check("bto_busy", {31'd0, busy}, 32'd0);
        send_frame(24'h000001);
        check("bto_next_addr", {7'd0, rd_req, addr}, {7'd0, 1'b1, 24'h000001});
        pulse_rd(16'h1234);
        wait_idle("bto_idle");
        check("bto_next_bytes", {16'd0, tx_q[q0], tx_q[q0+1]}, 32'h1234);

        // Read timeout, then a late strobe that must be ignored.
        e0 = err_cnt; q0 = tx_q.size();
        send_frame(24'hABCDEF);
        n = 0;
        while (rd_req && n < 100) begin
            tick(1);
            n++;
        end
        check("rto_req_cycles", n, RD_TO);
        check("rto_err", {31'd0, err}, 32'd1);
        check("rto_addr_hold", {8'd0, addr}, 32'hABCDEF);
        wait_idle("rto_idle");
        check("rto_tx", {tx_q.size() - q0 == 1, 23'd0, tx_q[q0]}, {1'b1, 23'd0, 8'hEE});
        pulse_rd(16'h5555);
        tick(20);
        check("late_rdy_ignored", {tx_q.size() - q0 == 1, busy, rd_req}, {1'b1, 1'b0, 1'b0});
        check("rto_err_once", err_cnt - e0, 32'd1);

        // Stray byte during REQ is dropped with an error strobe.
        e0 = err_cnt; q0 = tx_q.size();
        send_frame(24'h0A0B0C);
        send_byte(8'h77);
        check("stray_err", {31'd0, err}, 32'd1);
        check("stray_keeps_req", {7'd0, rd_req, addr}, {7'd0, 1'b1, 24'h0A0B0C});
        pulse_rd(16'hC0DE);
        wait_idle("stray_idle");
        check("stray_bytes", {tx_q.size() - q0 == 2, 7'd0, 8'd0, tx_q[q0], tx_q[q0+1]},
              {1'b1, 7'd0, 8'd0, 16'hC0DE});
        check("stray_err_once", err_cnt - e0, 32'd1);

        // Transmitter held busy before the high byte and across the byte boundary.
        q0 = tx_q.size(); bad_start = 0;
        send_frame(24'h001020);
        busy_force = 1'b1;
        pulse_rd(16'hA55A);
        tick(10);
        check("busy_hold_no_tx", tx_q.size() - q0, 32'd0);
        busy_force = 1'b0;
        #1;
        check("start_on_free", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'hA5});
        tick(1);
        busy_force = 1'b1;
        tick(50);
        check("boundary_one_byte", tx_q.size() - q0, 32'd1);
        busy_force = 1'b0;
        wait_idle("boundary_idle");
        check("boundary_bytes", {tx_q.size() - q0 == 2, 7'd0, 8'd0, tx_q[q0], tx_q[q0+1]},
              {1'b1, 7'd0, 8'd0, 16'hA55A});
        check("no_start_while_busy", bad_start, 32'd0);

        // Asynchronous reset while a read is pending.
        send_frame(24'h010203);
        check("pre_rst_req", {31'd0, rd_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {addr, rd_req, tx_start, busy, err}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        q0 = tx_q.size();
        send_frame(24'hFFFFFF);
        check("post_rst_addr", {7'd0, rd_req, addr}, {7'd0, 1'b1, 24'hFFFFFF});
        pulse_rd(16'h0102);
        wait_idle("post_rst_idle");
        check("post_rst_bytes", {16'd0, tx_q[q0], tx_q[q0+1]}, 32'h0102);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_sdram_bridge.md
UART_SDRAM_BRIDGE -- requirements
Module: uart_sdram_bridge

Interface
REQ-001 The block SHALL have parameter RD_TIMEOUT, default 255, giving the maximum number of cycles rd_req waits for rd_ready.
REQ-002 The block SHALL have parameter BYTE_TIMEOUT, default 1000000, giving the maximum number of cycles allowed between bytes of one command frame.
REQ-003 The block SHALL have the following ports, one per line as name, direction, width, meaning.
- clk_100MHz  in  1  system clock, 100 MHz; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle strobe; transmitter loads tx_data.
- tx_busy  in  1  transmitter busy; high from the cycle after tx_start until the frame is done.
- addr  out  24  SDRAM word address to the controller.
- rd_req  out  1  read request level to the controller.
- rd_data  in  16  read data from the controller.
- rd_ready  in  1  one-cycle strobe; rd_data valid.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle error strobe.

Function
REQ-004 Command frame format SHALL be: byte 0x52 ('R'), then three address bytes, MSB first: addr[23:16], addr[15:8], addr[7:0].
REQ-005 The state machine SHALL have exactly these states: IDLE, ADDR, REQ, TX_HI, TX_LO, TX_ERR.
REQ-006 In IDLE, on rx_valid with rx_data==0x52, the block SHALL clear the 2-bit byte counter and go to ADDR.
REQ-007 In IDLE, on rx_valid with any other byte, the block SHALL pulse err, load tx_data=0x3F, and go to TX_ERR.
REQ-008 In ADDR, each rx_valid SHALL shift rx_data into an internal address shift register and increment the byte counter.
REQ-009 On the third address byte, the block SHALL load the 24-bit value onto addr, assert rd_req on the next cycle, and go to REQ.
REQ-010 In ADDR, if BYTE_TIMEOUT cycles elapse without rx_valid, the block SHALL pulse err and return to IDLE; no byte is transmitted.
REQ-011 The inter-byte timer SHALL restart on every accepted rx_valid.
REQ-012 addr SHALL hold stable from rd_req assertion until the cycle after rd_req deasserts.
REQ-013 addr SHALL change only at the transition ADDR->REQ.
REQ-014 rd_req SHALL be a level, held high in REQ until the cycle in which rd_ready==1 is sampled.
REQ-015 rd_req SHALL deassert on the next edge after rd_ready is sampled.
REQ-016 In the cycle rd_ready==1, the block SHALL capture rd_data into a 16-bit holding register and go to TX_HI.
REQ-017 In REQ, if RD_TIMEOUT cycles elapse without rd_ready, the block SHALL drop rd_req, pulse err, load tx_data=0xEE, and go to TX_ERR.
REQ-018 A late rd_ready arriving outside REQ SHALL be ignored.
REQ-019 Transmit handshake:
- tx_start SHALL pulse for exactly one cycle, only when tx_busy==0.
- tx_data SHALL be valid in the same cycle as tx_start.
- After tx_start, the block SHALL ignore tx_busy for one guard cycle, then wait for tx_busy==0 before leaving the state.
REQ-020 In TX_HI, the block SHALL send the held rd_data[15:8], then go to TX_LO.
REQ-021 In TX_LO, the block SHALL send the held rd_data[7:0], then go to IDLE.
REQ-022 In TX_ERR, the block SHALL send the loaded error byte, then go to IDLE.
REQ-023 Read latency: tx_start for the high byte SHALL occur 1 cycle after rd_ready if tx_busy==0 at that point, otherwise on the first cycle tx_busy==0.
REQ-024 An rx_valid received in REQ, TX_HI, TX_LO or TX_ERR SHALL be dropped and SHALL pulse err; state and data SHALL be unaffected.
REQ-025 If rx_valid and a timeout expiry fall in the same cycle, the timeout SHALL take priority.
REQ-026 If rd_ready and RD_TIMEOUT expiry fall in the same cycle, rd_ready SHALL take priority and no error is reported.
REQ-027 busy SHALL be registered and SHALL equal (state != IDLE).

Reset
REQ-028 While rst_n==0, the block SHALL force state=IDLE and set every output to 0: addr, rd_req, tx_data, tx_start, busy, err.
REQ-029 While rst_n==0, all internal counters and the holding register SHALL be cleared.
REQ-030 Reset asserted mid-frame or mid-read SHALL abort immediately, with rd_req low within the reset assertion.
REQ-031 After reset release, the first frame SHALL be processed normally.

Verification
REQ-032 Send bytes 52 12 34 56 -> rd_req rises 1 cycle after byte 4 with addr=0x123456; drive rd_ready with rd_data=0xBEEF -> tx sends BE then EF; busy returns to 0.
REQ-033 Send byte 0x41 -> err pulses once; tx sends 3F; no rd_req.
REQ-034 Send 52 12, then idle for BYTE_TIMEOUT cycles -> err pulses; no tx_start; busy=0; next frame 52 00 00 01 reads addr=0x000001.
REQ-035 Valid frame, rd_ready never driven -> rd_req drops after RD_TIMEOUT cycles; err pulses; tx sends EE; a later rd_ready strobe is ignored.
REQ-036 Hold tx_busy=1 for 50 cycles across the hi/lo byte boundary -> no tx_start while busy; both bytes are sent in order, exactly once each.
REQ-037 Assert rst_n=0 while rd_req=1 -> all outputs 0 asynchronously; after release, frame 52 FF FF FF yields addr=0xFFFFFF.
